// File: rtl/cnn_acc_pkg.sv
// Shared CNN accelerator definitions: feature-map BRAM geometry, arbiter
// state encoding, requester ids and a saturating counter helper.
package cnn_acc_pkg;

    localparam int FM_AW = 12;
    localparam int FM_DW = 64;

    typedef enum logic [1:0] {
        IDLE_RR = 2'd0,
        LOCK0   = 2'd1,
        LOCK1   = 2'd2
    } arb_state_e;

    localparam logic REQ_PE = 1'b0;
    localparam logic REQ_WB = 1'b1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
        logic [31:0] res;
        if (en && (val != 32'hFFFF_FFFF)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/fmap_bram_arbiter_if.sv
// One requester's view of the feature-map BRAM arbiter: request beat,
// acceptance and the returned read data.
interface fmap_req_if
    import cnn_acc_pkg::*;
#(
    parameter int AW = FM_AW,
    parameter int DW = FM_DW
);
    logic          valid;
    logic          ready;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output valid, we, lock, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, lock, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/fmap_bram_arbiter_rd_tag_pipe.sv
// {valid, requester id} shift register that follows each read through the
// BRAM pipeline so the data can be steered back to its issuer.
module rd_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tag_valid_i,
    input  logic tag_id_i,
    output logic tag_valid_o,
    output logic tag_id_o,
    output logic any_valid_o
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] id_q;

    // advance every tag by one stage per clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], tag_valid_i};
            id_q  <= {id_q[DEPTH-2:0], tag_id_i};
        end
    end

    assign tag_valid_o = vld_q[DEPTH-1];
    assign tag_id_o    = id_q[DEPTH-1];
    assign any_valid_o = |vld_q;
endmodule

// File: rtl/fmap_bram_arbiter.sv
// Round-robin / burst-lock arbiter sharing one feature-map BRAM port between
// PE operand fetch and write-back. FMAP_ARB_STATS_EN adds contention counters.
module fmap_bram_arbiter
    import cnn_acc_pkg::*;
#(
    parameter int AW     = FM_AW,
    parameter int DW     = FM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fmap_req_if.slave     req0_if,
    fmap_req_if.slave     req1_if,
    output logic [AW-1:0] bram_addr_o,
    output logic [DW-1:0] bram_din_o,
    output logic          bram_we_o,
    input  logic [DW-1:0] bram_dout_i,
    output logic          busy_o
`ifdef FMAP_ARB_STATS_EN
    ,
    output logic [31:0]   stat_conflicts_o,
    output logic [31:0]   stat_stall0_o
`endif
);
    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic          gnt0_s, gnt1_s, acc_s;
    logic          sel_we_s, sel_lock_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          we_q;
    logic          tag_valid_s, tag_id_s, tag_any_s;

    // grant selection and arbitration next state
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE_RR: begin
                if (req0_if.valid && req1_if.valid) begin
                    gnt0_s = (last_q == REQ_WB);
                    gnt1_s = (last_q == REQ_PE);
                end else begin
                    gnt0_s = req0_if.valid;
                    gnt1_s = req1_if.valid;
                end
            end
            LOCK0:   gnt0_s = req0_if.valid;
            LOCK1:   gnt1_s = req1_if.valid;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        acc_s       = gnt0_s | gnt1_s;
        sel_we_s    = gnt1_s ? req1_if.we    : req0_if.we;
        sel_lock_s  = gnt1_s ? req1_if.lock  : req0_if.lock;
        sel_addr_s  = gnt1_s ? req1_if.addr  : req0_if.addr;
        sel_wdata_s = gnt1_s ? req1_if.wdata : req0_if.wdata;
        if (acc_s) begin
            last_d = gnt1_s;
            if (sel_lock_s) begin
                state_d = gnt1_s ? LOCK1 : LOCK0;
            end else begin
                state_d = IDLE_RR;
            end
        end else begin
            // a corrupted state register recovers to round-robin
            state_d = (state_q inside {IDLE_RR, LOCK0, LOCK1}) ? state_q : IDLE_RR;
        end
    end

    // arbitration state and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE_RR;
            last_q  <= REQ_WB;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // BRAM port register; addr/din hold when idle so the BRAM sees no toggling
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
        end else if (acc_s) begin
            addr_q <= sel_addr_s;
            din_q  <= sel_wdata_s;
            we_q   <= sel_we_s;
        end else begin
            addr_q <= addr_q;
            din_q  <= din_q;
            we_q   <= 1'b0;
        end
    end

    rd_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_tag_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tag_valid_i (acc_s & ~sel_we_s),
        .tag_id_i    (gnt1_s),
        .tag_valid_o (tag_valid_s),
        .tag_id_o    (tag_id_s),
        .any_valid_o (tag_any_s)
    );

    assign req0_if.ready     = gnt0_s;
    assign req1_if.ready     = gnt1_s;
    assign req0_if.rsp_valid = tag_valid_s & (tag_id_s == REQ_PE);
    assign req1_if.rsp_valid = tag_valid_s & (tag_id_s == REQ_WB);
    assign req0_if.rsp_rdata = req0_if.rsp_valid ? bram_dout_i : '0;
    assign req1_if.rsp_rdata = req1_if.rsp_valid ? bram_dout_i : '0;
    assign bram_addr_o       = addr_q;
    assign bram_din_o        = din_q;
    assign bram_we_o         = we_q;
    assign busy_o            = tag_any_s | (state_q != IDLE_RR);

`ifdef FMAP_ARB_STATS_EN
    logic [31:0] conflicts_q, stall0_q;

    // saturating contention counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflicts_q <= 32'd0;
            stall0_q    <= 32'd0;
        end else begin
            conflicts_q <= sat_inc32(conflicts_q,
                                     req0_if.valid & req1_if.valid & (state_q == IDLE_RR));
            stall0_q    <= sat_inc32(stall0_q, req0_if.valid & ~gnt0_s);
        end
    end

    assign stat_conflicts_o = conflicts_q;
    assign stat_stall0_o    = stall0_q;
`endif
endmodule
